// File: rtl/cache_wb_reader_if.sv
// Writeback read engine bundle: request/status, cache array read port and beat stream.
// The master view belongs to the engine and the slave view to its environment.
interface cache_wb_reader_if #(
    parameter int BEAT_BITS = 3
);
    localparam int LW = 10 - BEAT_BITS;

    logic          wb_req;
    logic [LW-1:0] wb_line;
    logic          wb_busy;
    logic          wb_done;
    logic [12:0]   cache_raddr;
    logic [63:0]   cache_do;
    logic [63:0]   out_data;
    logic          out_valid;
    logic          out_ready;
    logic          out_last;

    modport master (
        input  wb_req, wb_line, cache_do, out_ready,
        output wb_busy, wb_done, cache_raddr, out_data, out_valid, out_last
    );

    modport slave (
        output wb_req, wb_line, cache_do, out_ready,
        input  wb_busy, wb_done, cache_raddr, out_data, out_valid, out_last
    );
endinterface

// File: rtl/cache_wb_reader.sv
// Reads one cache line out of the registered-read data array, one 64-bit beat per address,
// and streams it through a 2-entry FIFO so that backpressure never loses or repeats a beat.
module cache_wb_reader #(
    parameter int BEAT_BITS = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    cache_wb_reader_if.master bus
);
    localparam int LW = 10 - BEAT_BITS;
    localparam logic [BEAT_BITS-1:0] LAST_BEAT = {BEAT_BITS{1'b1}};
    localparam logic [BEAT_BITS-1:0] BEAT_ONE  = {{(BEAT_BITS-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t               state_r;
    state_t               state_s;
    logic [LW-1:0]        line_r;
    logic [BEAT_BITS-1:0] issue_ptr_r;
    logic [BEAT_BITS-1:0] pop_cnt_r;
    logic                 inflight_r;
    logic                 inflight_last_r;
    logic [63:0]          fifo_data_r [2];
    logic [1:0]           fifo_last_r;
    logic                 wr_ptr_r;
    logic                 rd_ptr_r;
    logic [1:0]           count_r;
    logic                 done_r;

    logic                 accept_s;
    logic                 issue_en_s;
    logic                 push_s;
    logic                 pop_s;
    logic                 last_pop_s;

    assign bus.out_valid   = (count_r != 2'd0);
    assign bus.out_data    = fifo_data_r[rd_ptr_r];
    assign bus.out_last    = bus.out_valid && fifo_last_r[rd_ptr_r];
    assign bus.cache_raddr = {line_r, issue_ptr_r, 3'b000};
    assign bus.wb_busy     = (state_r != IDLE);
    assign bus.wb_done     = done_r;

    // Handshake decode and issue throttle: a beat is only issued if it is sure to find a FIFO slot.
    always_comb begin
        accept_s   = (state_r == IDLE) && bus.wb_req;
        pop_s      = bus.out_valid && bus.out_ready;
        push_s     = inflight_r;
        last_pop_s = pop_s && (pop_cnt_r == LAST_BEAT);
        issue_en_s = (state_r == READ) &&
                     (({1'b0, count_r} + {2'b00, inflight_r}) < (3'd2 + {2'b00, pop_s}));
    end

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    state_s = READ;
                end else begin
                    state_s = IDLE;
                end
            end
            READ: begin
                if (issue_en_s && (issue_ptr_r == LAST_BEAT)) begin
                    state_s = DRAIN;
                end else begin
                    state_s = READ;
                end
            end
            DRAIN: begin
                if (last_pop_s) begin
                    state_s = IDLE;
                end else begin
                    state_s = DRAIN;
                end
            end
            default: state_s = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Line capture, address/pop counters, read-latency tracking and the done pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            line_r          <= '0;
            issue_ptr_r     <= '0;
            pop_cnt_r       <= '0;
            inflight_r      <= 1'b0;
            inflight_last_r <= 1'b0;
            done_r          <= 1'b0;
        end else begin
            if (accept_s) begin
                line_r      <= bus.wb_line;
                issue_ptr_r <= '0;
                pop_cnt_r   <= '0;
            end else begin
                if (issue_en_s) begin
                    issue_ptr_r <= issue_ptr_r + BEAT_ONE;
                end
                if (pop_s) begin
                    pop_cnt_r <= pop_cnt_r + BEAT_ONE;
                end
            end
            inflight_r      <= issue_en_s;
            inflight_last_r <= issue_en_s && (issue_ptr_r == LAST_BEAT);
            done_r          <= (state_r == DRAIN) && last_pop_s;
        end
    end

    // Two-entry beat FIFO; cache_do is captured the edge after its address was issued.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fifo_data_r[0] <= 64'd0;
            fifo_data_r[1] <= 64'd0;
            fifo_last_r    <= 2'b00;
            wr_ptr_r       <= 1'b0;
            rd_ptr_r       <= 1'b0;
            count_r        <= 2'd0;
        end else begin
            if (push_s) begin
                fifo_data_r[wr_ptr_r] <= bus.cache_do;
                fifo_last_r[wr_ptr_r] <= inflight_last_r;
                wr_ptr_r              <= ~wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_r <= ~rd_ptr_r;
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + 2'd1;
                2'b01:   count_r <= count_r - 2'd1;
                default: count_r <= count_r;
            endcase
        end
    end
endmodule
